line_clear_engine: RTL and testbench

Sequential row-clear stage for the 10-wide x 22-tall game board (220 cells, 3-bit colour code each, 0 = empty). On a start pulse it snapshots the live board, removes every completely filled row, drops the rows above it and reports the count. Its board output feeds the B input of the board select mux. The controller selects B for one cycle when done pulses, which commits the cleared board.

---
 rtl/board_pkg.sv | 33 +++
 rtl/line_clear_engine_if.sv | 25 ++
 rtl/line_clear_engine_row_full_detect.sv | 19 +
 rtl/line_clear_engine.sv | 115 +++++++++++
 tb/tb_line_clear_engine.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Shared board definitions for the line-clear stage: geometry, cell type, FSM states, score table.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
// Contents: BOARD_ROWS/COLS/CELLS, cell_t, CELL_EMPTY, lc_state_t, score constants, line_score().
package board_pkg;

  localparam int BOARD_ROWS  = 22;
  localparam int BOARD_COLS  = 10;
  localparam int BOARD_CELLS = BOARD_ROWS * BOARD_COLS;

  typedef logic [2:0] cell_t;
  localparam cell_t CELL_EMPTY = 3'd0;

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} lc_state_t;

  localparam logic [10:0] SCORE_L0 = 11'd0;
  localparam logic [10:0] SCORE_L1 = 11'd40;
  localparam logic [10:0] SCORE_L2 = 11'd100;
  localparam logic [10:0] SCORE_L3 = 11'd300;
  localparam logic [10:0] SCORE_L4 = 11'd1200;

  // Anything beyond four lines is unreachable in legal play; pin it to the tetris score.
  function automatic logic [10:0] line_score(input logic [2:0] n);
    case (n)
      3'd0:    line_score = SCORE_L0;
      3'd1:    line_score = SCORE_L1;
      3'd2:    line_score = SCORE_L2;
      3'd3:    line_score = SCORE_L3;
      default: line_score = SCORE_L4;
    endcase
  endfunction

endpackage

// File: rtl/line_clear_engine_if.sv
// Request/result bundle between the board controller and the line-clear engine.
// Latency: n/a (wires only).
// Backpressure: none; start is a pulse honoured only while the engine is idle.
// Signals: start, board_in[219:0] (master->slave); board_out[219:0], busy, done, lines,
// and score when LINE_CLEAR_SCORE_EN is defined (slave->master).
interface line_clear_engine_if;
  import board_pkg::*;

  logic        start;
  cell_t       board_in  [BOARD_CELLS-1:0];
  cell_t       board_out [BOARD_CELLS-1:0];
  logic        busy;
  logic        done;
  logic [2:0]  lines;
`ifdef LINE_CLEAR_SCORE_EN
  logic [10:0] score;

  modport master (output start, board_in, input board_out, busy, done, lines, score);
  modport slave  (input start, board_in, output board_out, busy, done, lines, score);
`else
  modport master (output start, board_in, input board_out, busy, done, lines);
  modport slave  (input start, board_in, output board_out, busy, done, lines);
`endif

endinterface

// File: rtl/line_clear_engine_row_full_detect.sv
// Row-full detector: flags a board row whose cells are all non-empty.
// Latency: combinational.
// Backpressure: n/a.
// Ports: cells[BOARD_COLS-1:0] in, full out.
module row_full_detect
  import board_pkg::*;
(
  input  cell_t cells [BOARD_COLS-1:0],
  output logic  full
);

  always_comb begin
    full = 1'b1;
    for (int c = 0; c < BOARD_COLS; c++) begin
      if (cells[c] == CELL_EMPTY) full = 1'b0;
    end
  end

endmodule

// File: rtl/line_clear_engine.sv
// Sequential row clear: snapshots the board on start, removes full rows bottom-up, reports count.
// Latency: done on edge 1 + (ROWS + clears) + sum(r+1) over clears; 23 edges for no clears.
// Backpressure: start is ignored (not queued) unless idle; no stall once a pass is running.
// Ports: Clk, Reset_n (sync, active-low), io (line_clear_engine_if.slave).
// Optional LINE_CLEAR_SCORE_EN adds the registered io.score output, valid with done.
module line_clear_engine
  import board_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  line_clear_engine_if.slave  io
);

  lc_state_t   state;
  cell_t       board_q [BOARD_CELLS-1:0];
  logic [4:0]  row_q;     // row under inspection
  logic [4:0]  idx_q;     // destination row of the current shift step
  logic [2:0]  lines_q;
  logic        busy_q;
  logic        done_q;
`ifdef LINE_CLEAR_SCORE_EN
  logic [10:0] score_q;
`endif

  logic [7:0]  row_base;
  logic [7:0]  idx_base;
  cell_t       row_cells [BOARD_COLS-1:0];
  logic        row_full;

  always_comb begin
    row_base = 8'(row_q) * 8'(BOARD_COLS);
    idx_base = 8'(idx_q) * 8'(BOARD_COLS);
    for (int c = 0; c < BOARD_COLS; c++) begin
      row_cells[c] = board_q[row_base + 8'(c)];
    end
  end

  row_full_detect u_row_full (
    .cells (row_cells),
    .full  (row_full)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      for (int i = 0; i < BOARD_CELLS; i++) board_q[i] <= CELL_EMPTY;
      row_q   <= '0;
      idx_q   <= '0;
      lines_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
      score_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io.start) begin
            board_q <= io.board_in;
            row_q   <= 5'(BOARD_ROWS - 1);
            lines_q <= '0;
            busy_q  <= 1'b1;
`ifdef LINE_CLEAR_SCORE_EN
            score_q <= '0;
`endif
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (row_full) begin
            if (lines_q != 3'd7) lines_q <= lines_q + 3'd1;
            idx_q <= row_q;
            state <= SHIFT;
          end else if (row_q == 5'd0) begin
            state <= DONE;
          end else begin
            row_q <= row_q - 5'd1;
          end
        end
        SHIFT: begin
          // Move one row per cycle from the cleared row upward; row_q is left alone so
          // whatever dropped into it gets rechecked.
          if (idx_q != 5'd0) begin
            for (int c = 0; c < BOARD_COLS; c++) begin
              board_q[idx_base + 8'(c)] <= board_q[idx_base - 8'(BOARD_COLS) + 8'(c)];
            end
            idx_q <= idx_q - 5'd1;
          end else begin
            for (int c = 0; c < BOARD_COLS; c++) board_q[c] <= CELL_EMPTY;
            state <= CHECK;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
          score_q <= line_score(lines_q);
`endif
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.board_out = board_q;
  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.lines     = lines_q;
`ifdef LINE_CLEAR_SCORE_EN
  assign io.score     = score_q;
`endif

endmodule

// File: tb/tb_line_clear_engine.sv
// Self-checking bench for line_clear_engine: directed boards plus random boards against a
// row-list reference model (kept rows compacted to the bottom, timing from clear positions).
// Checks score too when LINE_CLEAR_SCORE_EN is defined.
module tb_line_clear_engine;
  import board_pkg::*;

  logic Clk;
  logic Reset_n;

  line_clear_engine_if bus ();

  line_clear_engine dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .io      (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int    vectors;
  int    miscompares;

  cell_t brd     [BOARD_CELLS-1:0];
  cell_t exp_brd [BOARD_CELLS-1:0];
  int    exp_lines;
  int    exp_edge;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic int exp_score(input int n);
    case (n)
      0: return 0;
      1: return 40;
      2: return 100;
      3: return 300;
      default: return 1200;
    endcase
  endfunction

  // Reference: scan bottom-up; a full row is reached at its original index pushed down by
  // every full row already removed beneath it, and costs (that index + 1) shift cycles.
  task automatic run_model();
    int k;
    int sh;
    int dst;
    bit full;
    k   = 0;
    sh  = 0;
    dst = BOARD_ROWS - 1;
    for (int i = 0; i < BOARD_CELLS; i++) exp_brd[i] = CELL_EMPTY;
    for (int r = BOARD_ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < BOARD_COLS; c++) if (brd[r*BOARD_COLS+c] == 3'd0) full = 1'b0;
      if (full) begin
        sh += r + k + 1;
        k++;
      end else begin
        for (int c = 0; c < BOARD_COLS; c++) exp_brd[dst*BOARD_COLS+c] = brd[r*BOARD_COLS+c];
        dst--;
      end
    end
    exp_lines = (k > 7) ? 7 : k;
    exp_edge  = 1 + BOARD_ROWS + k + sh;
  endtask

  task automatic check_board(input string tag, input bit expect_zero);
    logic [63:0] act;
    logic [63:0] exp;
    for (int r = 0; r < BOARD_ROWS; r++) begin
      act = '0;
      exp = '0;
      for (int c = 0; c < BOARD_COLS; c++) begin
        act[c*3 +: 3] = bus.board_out[r*BOARD_COLS+c];
        if (!expect_zero) exp[c*3 +: 3] = exp_brd[r*BOARD_COLS+c];
      end
      check($sformatf("%s_row%0d", tag, r), act, exp);
    end
  endtask

  task automatic clear_brd();
    for (int i = 0; i < BOARD_CELLS; i++) brd[i] = 3'd0;
  endtask

  task automatic fill_row(input int r);
    for (int c = 0; c < BOARD_COLS; c++) brd[r*BOARD_COLS+c] = cell_t'($urandom_range(1, 7));
  endtask

  task automatic random_brd();
    int mode;
    for (int r = 0; r < BOARD_ROWS; r++) begin
      mode = $urandom_range(0, 3);
      for (int c = 0; c < BOARD_COLS; c++) begin
        case (mode)
          0:       brd[r*BOARD_COLS+c] = 3'd0;
          1:       brd[r*BOARD_COLS+c] = cell_t'($urandom_range(1, 7));
          default: brd[r*BOARD_COLS+c] = cell_t'($urandom_range(0, 7));
        endcase
      end
    end
  endtask

  task automatic scramble_input();
    for (int i = 0; i < BOARD_CELLS; i++) bus.board_in[i] = cell_t'($urandom_range(1, 7));
  endtask

  // One pass: accept on edge 0, count edges to done, compare everything, then watch for
  // stray done pulses. With glitch set, start is re-pulsed at edge 10 with a new board.
  task automatic run_pass(input string tag, input bit glitch);
    int n;
    int busy_bad;
    int extra;
    bit got;
    run_model();
    bus.board_in = brd;
    bus.start    = 1'b1;
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
    scramble_input();
    n        = 0;
    busy_bad = 0;
    got      = 1'b0;
    while (n < 1500 && !got) begin
      @(posedge Clk);
      n++;
      #1;
      if (bus.done) got = 1'b1;
      else if (!bus.busy) busy_bad++;
      if (glitch && n == 9) begin
        bus.start = 1'b1;
        scramble_input();
      end
      if (glitch && n == 10) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    if (!got) begin
      check({tag, "_done_seen"}, 0, 1);
      return;
    end
    check({tag, "_done_edge"}, n, exp_edge);
    check({tag, "_busy_low_early"}, busy_bad, 0);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    check({tag, "_lines"}, bus.lines, exp_lines);
`ifdef LINE_CLEAR_SCORE_EN
    check({tag, "_score"}, bus.score, exp_score(exp_lines));
`endif
    check_board(tag, 1'b0);
    extra = 0;
    repeat (glitch ? 700 : 2) begin
      @(posedge Clk);
      #1;
      if (bus.done) extra++;
    end
    check({tag, "_extra_done"}, extra, 0);
    check({tag, "_lines_held"}, bus.lines, exp_lines);
  endtask

  task automatic reset_midpass();
    int extra;
    random_brd();
    fill_row(BOARD_ROWS - 1);
    bus.board_in = brd;
    bus.start    = 1'b1;
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
    repeat (19) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_done", bus.done, 0);
    check("rst_mid_lines", bus.lines, 0);
    check_board("rst_mid", 1'b1);
    Reset_n = 1'b1;
    extra = 0;
    repeat (600) begin
      @(posedge Clk);
      #1;
      if (bus.done) extra++;
    end
    check("rst_mid_no_done", extra, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset_n     = 1'b0;
    bus.start   = 1'b0;
    clear_brd();
    bus.board_in = brd;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_lines", bus.lines, 0);
`ifdef LINE_CLEAR_SCORE_EN
    check("rst_score", bus.score, 0);
`endif
    check_board("rst", 1'b1);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    clear_brd();
    run_pass("empty", 1'b0);

    clear_brd();
    for (int c = 0; c < BOARD_COLS; c++) brd[21*BOARD_COLS+c] = 3'd1;
    brd[20*BOARD_COLS+0] = 3'd2;
    run_pass("one21", 1'b0);

    clear_brd();
    for (int r = 18; r < 22; r++) fill_row(r);
    brd[17*BOARD_COLS+5] = 3'd4;
    run_pass("four", 1'b0);

    clear_brd();
    fill_row(21);
    fill_row(19);
    brd[20*BOARD_COLS+3] = 3'd5;
    run_pass("split", 1'b0);

    random_brd();
    run_pass("glitch", 1'b1);

    reset_midpass();

    clear_brd();
    for (int r = 0; r < BOARD_ROWS; r++) fill_row(r);
    run_pass("allfull", 1'b0);

    for (int t = 0; t < 15; t++) begin
      random_brd();
      run_pass($sformatf("rnd%0d", t), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
